// File: rtl/led_pwm_fader.sv
// Eight-channel PWM LED dimmer with saturating linear fade toward on/off targets.
// Define LED_PWM_FADER_GAMMA_EN to map levels through an approximate gamma-2.0 curve.
module led_pwm_fader #(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned FADE_DIV = 383
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] led,
   output logic       busy
);

   localparam int unsigned         PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PWM_BITS-1:0] lvl_q [8];
   logic [PWM_BITS-1:0] lvl_d [8];
   logic [PWM_BITS-1:0] shd_q [8];
   logic [PWM_BITS-1:0] shd_d [8];
   logic [7:0]          led_q, led_d;
   logic                busy_q, busy_d;
   logic                frame_end;
   logic                step;

`ifdef LED_PWM_FADER_GAMMA_EN
   // Top level stays fully on; squaring alone would stop one code short of MAX.
   function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] l);
      logic [2*PWM_BITS-1:0] sq;
      sq = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
      if (l == MAX) duty_of = MAX;
      else          duty_of = PWM_BITS'(sq >> PWM_BITS);
   endfunction
`else
   function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] l);
      duty_of = l;
   endfunction
`endif

   always_comb begin
      frame_end = (pwm_cnt_q == MAX);
      step      = frame_end && (pre_q == PRE_LAST);
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      pre_d     = pre_q;
      if (frame_end) pre_d = step ? '0 : pre_q + PRE_W'(1);
      busy_d    = 1'b0;
      led_d     = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         lvl_d[i] = lvl_q[i];
         if (step) begin
            if (req[i] && (lvl_q[i] != MAX))       lvl_d[i] = lvl_q[i] + PWM_BITS'(1);
            else if (!req[i] && (lvl_q[i] != '0))  lvl_d[i] = lvl_q[i] - PWM_BITS'(1);
         end
         // Shadow takes the post-step level so the new duty starts on the next frame.
         shd_d[i] = frame_end ? duty_of(lvl_d[i]) : shd_q[i];
         led_d[i] = (shd_q[i] == MAX) || (shd_q[i] > pwm_cnt_q);
         busy_d   = busy_d | (lvl_q[i] != (req[i] ? MAX : '0));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         pre_q     <= '0;
         lvl_q     <= '{default: '0};
         shd_q     <= '{default: '0};
         led_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pre_q     <= pre_d;
         lvl_q     <= lvl_d;
         shd_q     <= shd_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
      end
   end

   assign led  = led_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at PWM_BITS=4, FADE_DIV=2 (16-cycle frame, 32-cycle step).
`ifdef LED_PWM_FADER_GAMMA_EN
`define TB_PAT(lin, gam) (gam)
`else
`define TB_PAT(lin, gam) (lin)
`endif

module tb_led_pwm_fader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'hFF;
   logic [7:0] led;
   logic       busy;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   logic [15:0] pat;
   logic [6:0]  oth;

   led_pwm_fader #(.PWM_BITS(4), .FADE_DIV(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .led  (led),
      .busy (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // One reset edge, then the current cycle is post-release cycle 0.
   task automatic do_reset(input logic [7:0] r);
      rst = 1'b1;
      req = r;
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Bit j of pat = led[0] at cycle start+j; oth = OR of led[7:1] over the window.
   task automatic measure(input int start, output logic [15:0] p, output logic [6:0] o);
      run_to(start);
      p = '0;
      o = '0;
      for (int j = 0; j < 16; j++) begin
         p[j] = led[0];
         o    = o | led[7:1];
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (led !== 8'h00) $display("FAIL reset_led[%0d]: got %h expected 00", k, led);
         else passed++;
         total++;
         if (busy !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy);
         else passed++;
      end
      rst = 1'b0;
      cyc = 0;
      total++;
      if (busy !== 1'b0) $display("FAIL release_busy_c0: got %b expected 0", busy);
      else passed++;
      tick();
      total++;
      if (busy !== 1'b1) $display("FAIL release_busy_c1: got %b expected 1", busy);
      else passed++;
      total++;
      if (led !== 8'h00) $display("FAIL release_led_c1: got %h expected 00", led);
      else passed++;
   endtask

   task automatic test_ramp_up();
      do_reset(8'h01);
      measure(33, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h0001, 16'h0000)) $display("FAIL ramp_lvl1: got %h expected %h", pat, `TB_PAT(16'h0001, 16'h0000));
      else passed++;
      measure(161, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h001F, 16'h0001)) $display("FAIL ramp_lvl5: got %h expected %h", pat, `TB_PAT(16'h001F, 16'h0001));
      else passed++;
      run_to(200);
      total++;
      if (busy !== 1'b1) $display("FAIL ramp_busy_mid: got %b expected 1", busy);
      else passed++;
      measure(449, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h3FFF, 16'h0FFF)) $display("FAIL ramp_lvl14: got %h expected %h", pat, `TB_PAT(16'h3FFF, 16'h0FFF));
      else passed++;
      run_to(480);
      total++;
      if (busy !== 1'b1) $display("FAIL ramp_busy_c480: got %b expected 1", busy);
      else passed++;
      tick();
      total++;
      if (busy !== 1'b0) $display("FAIL ramp_busy_c481: got %b expected 0", busy);
      else passed++;
      measure(481, pat, oth);
      total++;
      if (pat !== 16'hFFFF) $display("FAIL ramp_full_on: got %h expected ffff", pat);
      else passed++;
      total++;
      if (oth !== 7'h00) $display("FAIL ramp_other_leds: got %h expected 00", oth);
      else passed++;
   endtask

   task automatic test_duty();
      do_reset(8'h01);
      run_to(161);
      req = 8'h00;
      measure(161, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h001F, 16'h0001)) $display("FAIL duty_lvl5_req_dropped: got %h expected %h", pat, `TB_PAT(16'h001F, 16'h0001));
      else passed++;
      req = 8'h01;
      measure(193, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h003F, 16'h0003)) $display("FAIL duty_lvl6: got %h expected %h", pat, `TB_PAT(16'h003F, 16'h0003));
      else passed++;
      run_to(223);
      req = 8'h00;
      tick();
      req = 8'h01;
      measure(225, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h001F, 16'h0001)) $display("FAIL duty_step_cycle_req: got %h expected %h", pat, `TB_PAT(16'h001F, 16'h0001));
      else passed++;
      measure(257, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h003F, 16'h0003)) $display("FAIL duty_after_resume: got %h expected %h", pat, `TB_PAT(16'h003F, 16'h0003));
      else passed++;
   endtask

   task automatic test_reversal();
      do_reset(8'h01);
      run_to(224);
      req = 8'h00;
      measure(257, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h003F, 16'h0003)) $display("FAIL rev_lvl6: got %h expected %h", pat, `TB_PAT(16'h003F, 16'h0003));
      else passed++;
      measure(417, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h0001, 16'h0000)) $display("FAIL rev_lvl1: got %h expected %h", pat, `TB_PAT(16'h0001, 16'h0000));
      else passed++;
      run_to(448);
      total++;
      if (busy !== 1'b1) $display("FAIL rev_busy_c448: got %b expected 1", busy);
      else passed++;
      tick();
      total++;
      if (busy !== 1'b0) $display("FAIL rev_busy_c449: got %b expected 0", busy);
      else passed++;
      measure(449, pat, oth);
      total++;
      if (pat !== 16'h0000) $display("FAIL rev_off: got %h expected 0000", pat);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset(8'h01);
      measure(273, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h00FF, 16'h000F)) $display("FAIL rstmid_lvl8: got %h expected %h", pat, `TB_PAT(16'h00FF, 16'h000F));
      else passed++;
      run_to(296);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (led !== 8'h00) $display("FAIL rstmid_led: got %h expected 00", led);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy);
      else passed++;
      cyc = 0;
      measure(1, pat, oth);
      total++;
      if (pat !== 16'h0000) $display("FAIL rstmid_frame0: got %h expected 0000", pat);
      else passed++;
      measure(65, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h0003, 16'h0000)) $display("FAIL rstmid_restart_lvl2: got %h expected %h", pat, `TB_PAT(16'h0003, 16'h0000));
      else passed++;
   endtask

   task automatic test_gamma();
      do_reset(8'h01);
      measure(257, pat, oth);
      total++;
      if (pat !== `TB_PAT(16'h00FF, 16'h000F)) $display("FAIL gamma_lvl8: got %h expected %h", pat, `TB_PAT(16'h00FF, 16'h000F));
      else passed++;
      measure(481, pat, oth);
      total++;
      if (pat !== 16'hFFFF) $display("FAIL gamma_lvl15: got %h expected ffff", pat);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_duty();
      test_reversal();
      test_reset_mid();
      test_gamma();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`undef TB_PAT

// File: doc/led_pwm_fader.md
# led_pwm_fader

Per-LED PWM dimmer with linear fade, sitting directly downstream of the free-running LED pattern counter and upstream of the board LED pins. Each of the 8 on/off request bits sets a brightness target, either full on or off. Each channel's brightness level ramps one step at a time toward its target at a fixed rate, so LEDs fade smoothly instead of switching hard. The outputs are registered PWM, glitch-free at frame boundaries.

## Interface
- `PWM_BITS`, default 8: width of the PWM counter and of each brightness level; frame length = 2^PWM_BITS cycles.
- `FADE_DIV`, default 383: number of PWM frames per fade step, must be ≥1. At 25 MHz the defaults give ≈1 s for a full ramp.
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  per-LED target: 1 = fade to full on, 0 = fade to off; same clock domain, no synchronizer.
- `led`  out 8  registered PWM drive, 1 = LED lit.
- `busy` out 1  registered; 1 while any channel level differs from its target.

## Operation
- **PWM counter** `pwm_cnt`, PWM_BITS wide:
  - free-running, increments every cycle, wraps from MAX = 2^PWM_BITS−1 to 0.
  - frame end = cycle where `pwm_cnt == MAX`.
- **Frame prescaler**, width clog2(FADE_DIV), minimum 1:
  - counts frame ends 0..FADE_DIV−1.
  - `step` strobe = frame end AND prescaler == FADE_DIV−1; prescaler wraps to 0 on the same edge.
- **Level registers** `lvl[i]`, PWM_BITS each. On `step` only, sampling `req[i]` that cycle:
  - `req[i]=1` and lvl<MAX: lvl+1.
  - `req[i]=0` and lvl>0: lvl−1.
  - otherwise hold. Saturating: no wrap at either end.
- **Shadow duty** `shd[i]`:
  - loaded on every frame end with the duty derived from the level value being written that edge (post-step).
  - `shd` is constant for the whole frame, so changes in `req` never produce a mid-frame glitch.
- **Output**: `led[i] <= (shd[i] == MAX) ? 1 : (shd[i] > pwm_cnt)`.
  - 0 → constantly off.
  - MAX → constantly on.
  - k → high for exactly k cycles per frame, at `pwm_cnt` 0..k−1.
- **busy**: `busy <= OR over i of (lvl[i] != (req[i] ? MAX : 0))`, evaluated on the current register values.
- **Simultaneous events**:
  - `req` toggling between steps has no effect until the next `step`.
  - a `req` change on the step cycle itself is honoured in that step.
  - a reversal mid-ramp continues from the current level in the new direction.

## Timing
- **Reset values**: `pwm_cnt`=0, prescaler=0, all `lvl`=0, all `shd`=0, `led`=8'h00, `busy`=0.
  - `rst` takes priority over everything, including mid-ramp or mid-frame.
  - In the cycle after release, `pwm_cnt`=1.
- Frame period: 2^PWM_BITS cycles.
- Step period: FADE_DIV·2^PWM_BITS cycles.
- First step: at the edge ending cycle FADE_DIV·2^PWM_BITS−1, counting the first post-reset cycle as 0.
- Full ramp 0→MAX or MAX→0 takes MAX steps.
- `led` lags its compare by 1 cycle: `led` at cycle t+1 reflects `pwm_cnt` and `shd` at cycle t.
- A new level becomes visible on `led` in the first cycle of the following frame plus 1 cycle of output latency.
- `busy` lags `lvl`/`req` by 1 cycle.

## Configuration
- `LED_PWM_FADER_GAMMA_EN` defined:
  - duty = (lvl·lvl) >> PWM_BITS (approximate perceptual gamma 2.0).
  - lvl == MAX is still forced fully on.
- Not defined: duty = lvl (linear); the squaring logic is absent.
- Fade timing and `busy` are identical in both builds.

## Test plan
All scenarios use PWM_BITS=4, FADE_DIV=2: frame = 16 cycles, step = 32 cycles.
- **Reset**: `rst`=1 for 3 cycles with `req`=8'hFF → `led`=8'h00 and `busy`=0 throughout reset; `busy`=1 from the 2nd cycle after release.
- **Ramp up**: `req`=8'h01 → `lvl[0]` increments every 32 cycles. After 15 steps (cycle 479 edge) `lvl[0]`=15, `led[0]` constantly 1 from the next frame, `busy` falls to 0; `led[7:1]` remain 0.
- **Duty**: hold `lvl[0]`=5 by dropping `req[0]` after the 5th step and restoring it → `led[0]` high exactly 5 of 16 cycles per frame, contiguous, starting 1 cycle after `pwm_cnt`=0. Checked non-gamma build.
- **Reversal**: `req[0]` 1→0 when `lvl[0]`=7 → next step gives 6, decreasing to 0 after 7 steps; then `led[0]` constantly 0 and `busy`=0.
- **Reset mid-operation**: `rst` asserted for 1 cycle with `lvl[0]`=9, mid-frame → next cycle `led`=0, `busy`=0, `pwm_cnt`=0; the ramp restarts from 0.
- **Gamma**: `LED_PWM_FADER_GAMMA_EN` defined, `lvl[0]`=8 → `led[0]` high 4 of 16 cycles (64>>4); `lvl[0]`=15 → constantly on. Without the macro, `lvl[0]`=8 gives 8 of 16.
